// File: rtl/moore_111010_pkg.sv
// Shared types and constants for the 111010 overlapping Moore detector.
package moore_111010_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "111"
    S4 = 3'd4,  // "1110"
    S5 = 3'd5,  // "11101"
    S6 = 3'd6   // "111010" detect
  } state_t;

  localparam logic [5:0] PATTERN   = 6'b111010;
  localparam state_t     DET_STATE = S6;

  // A 1 after "11101" leaves "11" as the longest usable suffix, hence S5 -> S2.
  function automatic state_t next_state(input state_t cur, input logic bit_in);
    state_t nxt;
    nxt = S0;
    case (cur)
      S0:      nxt = bit_in ? S1 : S0;
      S1:      nxt = bit_in ? S2 : S0;
      S2:      nxt = bit_in ? S3 : S0;
      S3:      nxt = bit_in ? S3 : S4;
      S4:      nxt = bit_in ? S5 : S0;
      S5:      nxt = bit_in ? S2 : S6;
      S6:      nxt = bit_in ? S1 : S0;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/moore_111010_if.sv
// Bundle for the detector's serial input, detect flag and detection count.
interface moore_111010_if #(
  parameter int CNT_W = 8
);
  logic             in_seq;
  logic             det_out;
  logic             hit;
  logic [CNT_W-1:0] count;

  modport master (output in_seq, input det_out, input count);
  modport slave  (input in_seq, output det_out, output count);
  modport cnt    (input hit, output count);
endinterface

// File: rtl/moore_111010_cnt.sv
// Saturating detection counter: +1 per hit, holds at all-ones, cleared only by rst.
module moore_111010_cnt (
  input logic         clk,
  input logic         rst,
  moore_111010_if.cnt bus
);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.count <= '0;
    end else if (bus.hit && !(&bus.count)) begin
      bus.count <= bus.count + 1'b1;
    end
  end

endmodule

// File: rtl/moore_111010_ov.sv
// Moore FSM detecting serial 1,1,1,0,1,0 with overlap; det_out is high in S6 only.
// Optional saturating det_count port is built when MOORE_111010_CNT_EN is defined.
module moore_111010_ov
  import moore_111010_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             in_seq,
  input  logic             clk,
  input  logic             rst,
  output logic             det_out
`ifdef MOORE_111010_CNT_EN
  ,
  output logic [CNT_W-1:0] det_count
`endif
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  // det_out is decoded from the state register only, never from in_seq.
  always_comb begin
    state_nxt = next_state(state, in_seq);
    det_out   = (state == DET_STATE);
  end

`ifdef MOORE_111010_CNT_EN
  moore_111010_if #(.CNT_W(CNT_W)) u_cnt_if ();

  assign u_cnt_if.hit = (state_nxt == DET_STATE);
  assign det_count    = u_cnt_if.count;

  moore_111010_cnt u_cnt (
    .clk (clk),
    .rst (rst),
    .bus (u_cnt_if.cnt)
  );
`endif

endmodule

// File: tb/tb_moore_111010_ov.sv
// Directed bench for moore_111010_ov: table of {rst, in_seq, expected det_out} plus corner sequences.
module tb_moore_111010_ov;

  logic clk = 1'b0;
  logic rst = 1'b1;

  moore_111010_if #(.CNT_W(8)) bus ();

  moore_111010_ov #(.CNT_W(8)) dut (
    .in_seq    (bus.in_seq),
    .clk       (clk),
    .rst       (rst),
    .det_out   (bus.det_out)
`ifdef MOORE_111010_CNT_EN
    ,
    .det_count (bus.count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic in_bit;
    logic exp_det;
  } vec_t;

  vec_t vecs[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  function automatic void push(input logic r, input logic b, input logic e);
    vec_t v;
    v.rst     = r;
    v.in_bit  = b;
    v.exp_det = e;
    vecs.push_back(v);
  endfunction

  // bits are sent MSB first; p1/p2 are 1-based bit positions after which det_out must be high.
  function automatic void push_seq(input logic [15:0] bits, input int n, input int p1, input int p2);
    for (int i = 0; i < n; i++) begin
      push(1'b0, bits[n-1-i], ((i + 1) == p1) || ((i + 1) == p2));
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic b);
    rst        = r;
    bus.in_seq = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_seq = 1'b0;

    push(1'b1, 1'b1, 1'b0);                         // reset with in_seq=1
    push_seq(16'b111010111010, 12, 6, 12);          // back-to-back
    push(1'b1, 1'b0, 1'b0);
    push_seq(16'b1111010, 7, 7, 0);                 // run of 1s stays in S3
    push(1'b1, 1'b0, 1'b0);
    push_seq(16'b1110111010, 10, 10, 0);            // S5 -> S2 overlap
    push(1'b1, 1'b0, 1'b0);
    push_seq(16'b111011, 6, 0, 0);
    push(1'b1, 1'b0, 1'b0);
    push_seq(16'b111000, 6, 0, 0);
    push(1'b1, 1'b0, 1'b0);
    push_seq(16'b110101, 6, 0, 0);
    push(1'b1, 1'b0, 1'b0);
    push_seq(16'b1110110, 7, 0, 0);
    push(1'b1, 1'b0, 1'b0);
    push_seq(16'b11101, 5, 0, 0);                   // partial pattern then reset
    push(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0);
    push_seq(16'b111010, 6, 6, 0);
    push(1'b1, 1'b0, 1'b0);                         // reset while in S6
    push(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].in_bit);
      check($sformatf("vec%0d_det_out", i), {31'd0, bus.det_out}, {31'd0, vecs[i].exp_det});
    end

    // det_out must not follow in_seq combinationally while in S6.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1); drive(1'b0, 1'b1); drive(1'b0, 1'b1);
    drive(1'b0, 1'b0); drive(1'b0, 1'b1); drive(1'b0, 1'b0);
    check("s6_det_high", {31'd0, bus.det_out}, 32'd1);
    bus.in_seq = 1'b1;
    #1;
    check("s6_in_toggle_hi", {31'd0, bus.det_out}, 32'd1);
    bus.in_seq = 1'b0;
    #1;
    check("s6_in_toggle_lo", {31'd0, bus.det_out}, 32'd1);
    drive(1'b0, 1'b1);
    check("s6_single_cycle", {31'd0, bus.det_out}, 32'd0);

`ifdef MOORE_111010_CNT_EN
    drive(1'b1, 1'b1);
    check("cnt_after_reset", {24'd0, bus.count}, 32'd0);
    check("det_after_reset", {31'd0, bus.det_out}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1); drive(1'b0, 1'b1); drive(1'b0, 1'b1);
      drive(1'b0, 1'b0); drive(1'b0, 1'b1); drive(1'b0, 1'b0);
      check($sformatf("cnt_b2b_%0d", k), {24'd0, bus.count}, k + 1);
    end
    for (int k = 0; k < 260; k++) begin
      drive(1'b0, 1'b1); drive(1'b0, 1'b1); drive(1'b0, 1'b1);
      drive(1'b0, 1'b0); drive(1'b0, 1'b1); drive(1'b0, 1'b0);
      if (k == 250) begin
        check("cnt_253", {24'd0, bus.count}, 32'd253);
      end
    end
    check("cnt_saturated", {24'd0, bus.count}, 32'd255);
    check("det_at_saturation", {31'd0, bus.det_out}, 32'd1);
    drive(1'b0, 1'b0);
    check("cnt_hold", {24'd0, bus.count}, 32'd255);
    drive(1'b1, 1'b0);
    check("cnt_cleared", {24'd0, bus.count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
